// File: rtl/uart_tx_fifo_bridge_pkg.sv
// Shared definitions for the UART TX FIFO bridge: drain FSM encoding and default sizing.
package uart_tx_fifo_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 7;

endpackage

// File: rtl/uart_tx_fifo_bridge_if.sv
// Start/data/busy handshake between the bridge (master) and the UART transmitter (slave).
interface uart_tx_fifo_bridge_if;

  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;

  modport master (
    output uart_tx_start,
    output uart_tx_data,
    input  uart_tx_busy
  );

  modport slave (
    input  uart_tx_start,
    input  uart_tx_data,
    output uart_tx_busy
  );

endinterface

// File: rtl/uart_tx_fifo_bridge_sync_fifo.sv
// Circular byte buffer with registered level, full/empty flags and sticky overflow.
module sync_fifo
  import uart_tx_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Flush takes priority over both ports, so a write in the flush cycle is silently discarded.
  assign push    = wr_en && !full && !flush;
  assign pop     = rd_en && !empty && !flush;
  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_bridge.sv
// Buffers CPU MMIO byte writes and drains them one at a time into the UART transmitter.
module uart_tx_fifo_bridge
  import uart_tx_fifo_bridge_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int PTR_W        = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        level,
  output logic                  overflow,
  output logic                  timeout_err,
  uart_tx_fifo_bridge_if.master tx
);

  localparam logic [2:0] TIMEOUT_LAST = 3'(BUSY_TIMEOUT - 1);

  tx_state_t  state;
  logic [2:0] ack_cnt;
  logic [7:0] head;
  logic       pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_valid),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // No launch in a flush cycle: the FIFO ignores the pop, so the head byte must not be sent.
  assign pop = (state == IDLE) && !empty && !tx.uart_tx_busy && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ack_cnt          <= '0;
      timeout_err      <= 1'b0;
      tx.uart_tx_start <= 1'b0;
      tx.uart_tx_data  <= '0;
    end else begin
      tx.uart_tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx.uart_tx_data  <= head;
            tx.uart_tx_start <= 1'b1;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx.uart_tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx.uart_tx_busy) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Scoreboard bench for uart_tx_fifo_bridge with a simple UART TX busy model.
module tb_uart_tx_fifo_bridge;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       timeout_err;

    uart_tx_fifo_bridge_if tx_if();

    uart_tx_fifo_bridge #(
        .DEPTH        (DEPTH),
        .PTR_W        (4),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .tx          (tx_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    bit          ack_en   = 1'b1;
    bit          hold     = 1'b0;
    bit          pending  = 1'b0;
    int          busy_len = 20;
    int          busy_cnt = 0;
    int          start_count = 0;
    int unsigned last_start_cyc = 0;
    logic [7:0]  last_rx = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // UART model: busy rises the cycle after a start and stays up busy_len cycles.
    initial begin
        tx_if.uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pending  = 1'b0;
                busy_cnt = 0;
                tx_if.uart_tx_busy = 1'b0;
                continue;
            end
            if (pending) begin
                pending  = 1'b0;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) check_eq("data_hold", tx_if.uart_tx_data, last_rx);
            end
            tx_if.uart_tx_busy = (busy_cnt > 0) || hold;
            if (tx_if.uart_tx_start) begin
                start_count++;
                last_start_cyc = cyc;
                last_rx        = tx_if.uart_tx_data;
                check_eq("start_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("rx_data", tx_if.uart_tx_data, exp_q.pop_front());
                if (ack_en) pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_accept);
        wr_valid = 1'b1;
        wr_data  = d;
        if (expect_accept) exp_q.push_back(d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_not_full(input int max);
        int n = 0;
        while (full && n < max) begin tick(); n++; end
        check_eq("wait_not_full", full, 0);
    endtask

    task automatic wait_busy(input int max);
        int n = 0;
        while (!tx_if.uart_tx_busy && n < max) begin tick(); n++; end
        check_eq("wait_busy", tx_if.uart_tx_busy, 1);
    endtask

    task automatic wait_drain(input int max, input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && !pending && !tx_if.uart_tx_busy && empty) && n < max) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, n < max, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned wc;
        int          sc;
        int          n;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        repeat (3) tick();
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_start", tx_if.uart_tx_start, 0);
        check_eq("rst_data", tx_if.uart_tx_data, 8'h00);
        reset = 1'b0;
        tick();

        // Single byte: start two cycles after the write cycle
        sc = start_count;
        wc = cyc;
        write_byte(8'h41, 1'b1);
        check_eq("single_level1", level, 1);
        check_eq("single_not_empty", empty, 0);
        tick();
        check_eq("single_empty", empty, 1);
        check_eq("single_latency", last_start_cyc - wc, 2);
        check_eq("single_starts", start_count - sc, 1);
        wait_drain(100, "single");

        // Burst of 16 with the transmitter held busy, then one dropped byte
        hold = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b1);
        check_eq("burst_full", full, 1);
        check_eq("burst_level", level, 16);
        check_eq("burst_no_overflow", overflow, 0);
        write_byte(8'hFF, 1'b0);
        check_eq("burst_overflow", overflow, 1);
        check_eq("burst_level_kept", level, 16);
        hold = 1'b0;
        wait_drain(700, "burst");
        check_eq("burst_level0", level, 0);

        // Wrap: 40 bytes with random gaps, short busy
        busy_len = 2;
        for (int i = 0; i < 40; i++) begin
            wait_not_full(200);
            write_byte(8'(8'h20 + i), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(500, "wrap");
        check_eq("wrap_level0", level, 0);
        check_eq("wrap_empty", empty, 1);

        // Flush while A0 is in flight; concurrent write is discarded
        busy_len = 20;
        check_eq("ovf_before_flush", overflow, 1);
        write_byte(8'hA0, 1'b1);
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        write_byte(8'hA3, 1'b0);
        wait_busy(20);
        tick();
        check_eq("flush_level_before", level, 3);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check_eq("flush_level", level, 0);
        check_eq("flush_empty", empty, 1);
        check_eq("flush_overflow", overflow, 0);
        wait_drain(100, "flush");

        // Timeout: no ack for 55, 56 still launched
        ack_en = 1'b0;
        write_byte(8'h55, 1'b1);
        write_byte(8'h56, 1'b1);
        n = 0;
        while (!timeout_err && n < 40) begin tick(); n++; end
        check_eq("timeout_set", timeout_err, 1);
        check_eq("timeout_delay", cyc - last_start_cyc, BUSY_TIMEOUT + 1);
        ack_en = 1'b1;
        wait_drain(100, "timeout");
        check_eq("timeout_sticky", timeout_err, 1);

        // Asynchronous reset during WAIT_DONE with 3 bytes queued
        write_byte(8'hC0, 1'b1);
        write_byte(8'hC1, 1'b0);
        write_byte(8'hC2, 1'b0);
        write_byte(8'hC3, 1'b0);
        wait_busy(20);
        tick();
        check_eq("areset_level_before", level, 3);
        reset = 1'b1;
        #1;
        check_eq("areset_start", tx_if.uart_tx_start, 0);
        check_eq("areset_data", tx_if.uart_tx_data, 8'h00);
        check_eq("areset_level", level, 0);
        check_eq("areset_empty", empty, 1);
        check_eq("areset_full", full, 0);
        check_eq("areset_overflow", overflow, 0);
        check_eq("areset_timeout", timeout_err, 0);
        tick();
        tick();
        reset = 1'b0;
        sc = start_count;
        repeat (30) tick();
        check_eq("post_reset_no_start", start_count - sc, 0);
        check_eq("post_reset_level", level, 0);
        check_eq("post_reset_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
